spi_reg_master: RTL

SPI master that executes single register transactions requested by the UART command controller. It takes a start pulse with read/write flag, register address and write data, then serialises one frame on a 4-wire SPI bus. It returns the read data and a one-cycle completion strobe. The block sits directly downstream of the controller's SPI request outputs and drives the device pins.

---
 rtl/spi_reg_master.sv | 134 +++++++++++++
 1 files changed

// File: rtl/spi_reg_master.sv
// SPI mode-0 master for single register transactions: one {rw, addr, data} frame per accepted start.
// All pins are registered copies of the FSM state, one cycle behind it.
module spi_reg_master #(
   parameter int SPI_ADDR_WIDTH = 6,
   parameter int SPI_DATA_WIDTH = 20,
   parameter int CLK_DIV        = 4
) (
   input  logic                      i_clk_sys,
   input  logic                      i_rst_n,
   input  logic                      i_spi_start,
   input  logic                      i_spi_rw,
   input  logic [SPI_ADDR_WIDTH-1:0] i_spi_addr,
   input  logic [SPI_DATA_WIDTH-1:0] i_spi_wdata,
   output logic [SPI_DATA_WIDTH-1:0] o_spi_rdata,
   output logic                      o_spi_data_valid,
   output logic                      o_spi_busy,
   output logic                      o_spi_cs_n,
   output logic                      o_spi_sclk,
   output logic                      o_spi_mosi,
   input  logic                      i_spi_miso
);
   // state | meaning
   // IDLE  | bus released, waiting for start
   // SETUP | cs_n low, first bit on mosi, CLK_DIV cycles before first rise
   // SHIFT | FRAME_LEN bit periods, high half then low half
   // DONE  | one cycle, completion strobe and read data update
   localparam int FRAME_LEN = 1 + SPI_ADDR_WIDTH + SPI_DATA_WIDTH;
   localparam int HW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BW        = $clog2(FRAME_LEN + 1);
   localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);

   typedef enum logic [1:0] {IDLE, SETUP, SHIFT, DONE} state_t;

   state_t                    state, state_nxt;
   logic [HW-1:0]             half_cnt, half_cnt_nxt;
   logic [BW-1:0]             bit_cnt, bit_cnt_nxt;
   logic                      phase_high, phase_high_nxt;
   logic [FRAME_LEN-1:0]      shreg, shreg_nxt;
   logic                      rw_q, rw_nxt;
   logic [SPI_DATA_WIDTH-1:0] rx, rx_nxt;
   logic                      half_end;

   always_comb begin
      state_nxt      = state;
      half_cnt_nxt   = half_cnt;
      bit_cnt_nxt    = bit_cnt;
      phase_high_nxt = phase_high;
      shreg_nxt      = shreg;
      rw_nxt         = rw_q;
      rx_nxt         = rx;
      half_end       = (half_cnt == HALF_LAST);
      case (state)
         IDLE: begin
            if (i_spi_start) begin
               shreg_nxt    = {i_spi_rw, i_spi_addr,
                               i_spi_rw ? {SPI_DATA_WIDTH{1'b0}} : i_spi_wdata};
               rw_nxt       = i_spi_rw;
               half_cnt_nxt = '0;
               state_nxt    = SETUP;
            end
         end
         SETUP: begin
            if (half_end) begin
               half_cnt_nxt   = '0;
               phase_high_nxt = 1'b1;
               bit_cnt_nxt    = BW'(FRAME_LEN);
               state_nxt      = SHIFT;
            end else begin
               half_cnt_nxt = half_cnt + 1'b1;
            end
         end
         SHIFT: begin
            // first high cycle is the edge on which the sclk pin rises
            if (phase_high && (half_cnt == '0)) begin
               rx_nxt = {rx[SPI_DATA_WIDTH-2:0], i_spi_miso};
            end
            if (!half_end) begin
               half_cnt_nxt = half_cnt + 1'b1;
            end else begin
               half_cnt_nxt   = '0;
               phase_high_nxt = !phase_high;
               if (phase_high) begin
                  shreg_nxt = {shreg[FRAME_LEN-2:0], 1'b0};
               end else begin
                  bit_cnt_nxt = bit_cnt - 1'b1;
                  if (bit_cnt == BW'(1)) begin
                     state_nxt = DONE;
                  end
               end
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk_sys) begin
      if (!i_rst_n) begin
         state            <= IDLE;
         half_cnt         <= '0;
         bit_cnt          <= '0;
         phase_high       <= 1'b0;
         shreg            <= '0;
         rw_q             <= 1'b0;
         rx               <= '0;
         o_spi_cs_n       <= 1'b1;
         o_spi_sclk       <= 1'b0;
         o_spi_mosi       <= 1'b0;
         o_spi_busy       <= 1'b0;
         o_spi_data_valid <= 1'b0;
         o_spi_rdata      <= '0;
      end else begin
         state            <= state_nxt;
         half_cnt         <= half_cnt_nxt;
         bit_cnt          <= bit_cnt_nxt;
         phase_high       <= phase_high_nxt;
         shreg            <= shreg_nxt;
         rw_q             <= rw_nxt;
         rx               <= rx_nxt;
         o_spi_cs_n       <= !((state == SETUP) || (state == SHIFT));
         o_spi_sclk       <= (state == SHIFT) && phase_high;
         o_spi_mosi       <= ((state == SETUP) || (state == SHIFT)) && shreg[FRAME_LEN-1];
         o_spi_busy       <= (state != IDLE);
         o_spi_data_valid <= (state == DONE);
         if ((state == DONE) && rw_q) begin
            o_spi_rdata <= rx;
         end
      end
   end
endmodule
